// File: rtl/tap_pkg.sv
// tap_pkg: shared JTAG TAP state encoding
package tap_pkg;
  typedef enum logic [3:0] {
    TLR      = 4'h0,
    RTI      = 4'h1,
    SEL_DR   = 4'h2,
    CAP_DR   = 4'h3,
    SHIFT_DR = 4'h4,
    EXIT1_DR = 4'h5,
    PAUSE_DR = 4'h6,
    EXIT2_DR = 4'h7,
    UPD_DR   = 4'h8,
    SEL_IR   = 4'h9,
    CAP_IR   = 4'ha,
    SHIFT_IR = 4'hb,
    EXIT1_IR = 4'hc,
    PAUSE_IR = 4'hd,
    EXIT2_IR = 4'he,
    UPD_IR   = 4'hf
  } tap_state_t;
endpackage

// File: rtl/tap_controller.sv
// tap_controller: IEEE 1149.1 TAP state machine with DR/IR control decode
module tap_controller
  import tap_pkg::*;
(
  input  logic TCK,
  input  logic TRST,
  input  logic TMS,
  output logic clockdr,
  output logic shiftdr,
  output logic updatedr,
  output logic clockir,
  output logic shiftir,
  output logic updateir,
  output logic select,
  output logic bs_en
);
  tap_state_t state, state_nx;
  always_comb begin
    state_nx = TLR;
    case (state)
      TLR:      state_nx = TMS ? TLR      : RTI;
      RTI:      state_nx = TMS ? SEL_DR   : RTI;
      SEL_DR:   state_nx = TMS ? SEL_IR   : CAP_DR;
      CAP_DR:   state_nx = TMS ? EXIT1_DR : SHIFT_DR;
      SHIFT_DR: state_nx = TMS ? EXIT1_DR : SHIFT_DR;
      EXIT1_DR: state_nx = TMS ? UPD_DR   : PAUSE_DR;
      PAUSE_DR: state_nx = TMS ? EXIT2_DR : PAUSE_DR;
      EXIT2_DR: state_nx = TMS ? UPD_DR   : SHIFT_DR;
      UPD_DR:   state_nx = TMS ? SEL_DR   : RTI;
      SEL_IR:   state_nx = TMS ? TLR      : CAP_IR;
      CAP_IR:   state_nx = TMS ? EXIT1_IR : SHIFT_IR;
      SHIFT_IR: state_nx = TMS ? EXIT1_IR : SHIFT_IR;
      EXIT1_IR: state_nx = TMS ? UPD_IR   : PAUSE_IR;
      PAUSE_IR: state_nx = TMS ? EXIT2_IR : PAUSE_IR;
      EXIT2_IR: state_nx = TMS ? UPD_IR   : SHIFT_IR;
      UPD_IR:   state_nx = TMS ? SEL_DR   : RTI;
      default:  state_nx = TLR;
    endcase
  end
  always_ff @(posedge TCK or negedge TRST)
    if (!TRST) state <= TLR;
    else state <= state_nx;
  // outputs decode the state register directly so an async reset clears them at once
  assign clockdr  = (state == CAP_DR) || (state == SHIFT_DR);
  assign shiftdr  = state == SHIFT_DR;
  assign updatedr = state == UPD_DR;
  assign clockir  = (state == CAP_IR) || (state == SHIFT_IR);
  assign shiftir  = state == SHIFT_IR;
  assign updateir = state == UPD_IR;
  assign select   = state inside {SEL_IR, CAP_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPD_IR};
  assign bs_en    = (state == SHIFT_DR) || (state == SHIFT_IR);
endmodule

// File: tb/tb_tap_controller.sv
// tb_tap_controller: directed-vector check of the TAP state walk and output decode
module tb_tap_controller;
  logic TCK = 1'b0, TRST = 1'b0, TMS = 1'b0;
  logic clockdr, shiftdr, updatedr, clockir, shiftir, updateir, select, bs_en;
  logic [7:0] outs;
  int tests = 0, failed = 0;

  // bit order: clockdr shiftdr updatedr clockir shiftir updateir select bs_en
  localparam logic [7:0] O_IDLE  = 8'h00;
  localparam logic [7:0] O_CAPDR = 8'h80;
  localparam logic [7:0] O_SHDR  = 8'hc1;
  localparam logic [7:0] O_UPDR  = 8'h20;
  localparam logic [7:0] O_IRSEL = 8'h02;
  localparam logic [7:0] O_CAPIR = 8'h12;
  localparam logic [7:0] O_SHIR  = 8'h1b;
  localparam logic [7:0] O_UPIR  = 8'h06;

  tap_controller dut (
    .TCK(TCK), .TRST(TRST), .TMS(TMS),
    .clockdr(clockdr), .shiftdr(shiftdr), .updatedr(updatedr),
    .clockir(clockir), .shiftir(shiftir), .updateir(updateir),
    .select(select), .bs_en(bs_en)
  );

  assign outs = {clockdr, shiftdr, updatedr, clockir, shiftir, updateir, select, bs_en};

  always #5 TCK = ~TCK;

  task automatic step(input logic tms);
    TMS = tms;
    @(posedge TCK);
    #1;
  endtask

  task automatic test_reset;
    TRST = 1'b0; TMS = 1'b0;
    repeat (2) @(posedge TCK);
    #1;
    tests++; if (outs !== O_IDLE) begin failed++; $display("FAIL reset_hold outs=%h exp=%h", outs, O_IDLE); end
    #2 TRST = 1'b1;
    step(1'b0);
    tests++; if (outs !== O_IDLE) begin failed++; $display("FAIL reset_rti outs=%h exp=%h", outs, O_IDLE); end
  endtask

  task automatic test_dr_scan;
    step(1'b0);
    tests++; if (outs !== O_IDLE) begin failed++; $display("FAIL rti_hold outs=%h exp=%h", outs, O_IDLE); end
    step(1'b1);
    tests++; if (outs !== O_IDLE) begin failed++; $display("FAIL sel_dr outs=%h exp=%h", outs, O_IDLE); end
    step(1'b0);
    tests++; if (outs !== O_CAPDR) begin failed++; $display("FAIL cap_dr outs=%h exp=%h", outs, O_CAPDR); end
    step(1'b0);
    tests++; if (outs !== O_SHDR) begin failed++; $display("FAIL shift_dr outs=%h exp=%h", outs, O_SHDR); end
    step(1'b0);
    tests++; if (outs !== O_SHDR) begin failed++; $display("FAIL shift_dr_hold outs=%h exp=%h", outs, O_SHDR); end
    step(1'b1);
    tests++; if (outs !== O_IDLE) begin failed++; $display("FAIL exit1_dr outs=%h exp=%h", outs, O_IDLE); end
    step(1'b1);
    tests++; if (outs !== O_UPDR) begin failed++; $display("FAIL upd_dr outs=%h exp=%h", outs, O_UPDR); end
  endtask

  task automatic test_ir_scan;
    step(1'b1);
    tests++; if (outs !== O_IDLE) begin failed++; $display("FAIL ir_sel_dr outs=%h exp=%h", outs, O_IDLE); end
    step(1'b1);
    tests++; if (outs !== O_IRSEL) begin failed++; $display("FAIL sel_ir outs=%h exp=%h", outs, O_IRSEL); end
    step(1'b0);
    tests++; if (outs !== O_CAPIR) begin failed++; $display("FAIL cap_ir outs=%h exp=%h", outs, O_CAPIR); end
    step(1'b0);
    tests++; if (outs !== O_SHIR) begin failed++; $display("FAIL shift_ir outs=%h exp=%h", outs, O_SHIR); end
    step(1'b1);
    tests++; if (outs !== O_IRSEL) begin failed++; $display("FAIL exit1_ir outs=%h exp=%h", outs, O_IRSEL); end
    step(1'b1);
    tests++; if (outs !== O_UPIR) begin failed++; $display("FAIL upd_ir outs=%h exp=%h", outs, O_UPIR); end
  endtask

  task automatic test_pause;
    step(1'b1); step(1'b0); step(1'b0);
    tests++; if (outs !== O_SHDR) begin failed++; $display("FAIL p_shift_dr outs=%h exp=%h", outs, O_SHDR); end
    step(1'b1); step(1'b0); step(1'b0);
    tests++; if (outs !== O_IDLE) begin failed++; $display("FAIL pause_dr outs=%h exp=%h", outs, O_IDLE); end
    step(1'b1);
    tests++; if (outs !== O_IDLE) begin failed++; $display("FAIL exit2_dr outs=%h exp=%h", outs, O_IDLE); end
    step(1'b0);
    tests++; if (outs !== O_SHDR) begin failed++; $display("FAIL resume_dr outs=%h exp=%h", outs, O_SHDR); end
    step(1'b1); step(1'b0); step(1'b1); step(1'b1);
    tests++; if (outs !== O_UPDR) begin failed++; $display("FAIL exit2_upd_dr outs=%h exp=%h", outs, O_UPDR); end
    step(1'b1); step(1'b1); step(1'b0); step(1'b0); step(1'b1); step(1'b0);
    tests++; if (outs !== O_IRSEL) begin failed++; $display("FAIL pause_ir outs=%h exp=%h", outs, O_IRSEL); end
    step(1'b1);
    tests++; if (outs !== O_IRSEL) begin failed++; $display("FAIL exit2_ir outs=%h exp=%h", outs, O_IRSEL); end
    step(1'b0);
    tests++; if (outs !== O_SHIR) begin failed++; $display("FAIL resume_ir outs=%h exp=%h", outs, O_SHIR); end
  endtask

  task automatic test_tlr_walk;
    repeat (5) step(1'b1);
    tests++; if (outs !== O_IDLE) begin failed++; $display("FAIL five_ones outs=%h exp=%h", outs, O_IDLE); end
    step(1'b1);
    tests++; if (outs !== O_IDLE) begin failed++; $display("FAIL tlr_hold outs=%h exp=%h", outs, O_IDLE); end
    step(1'b0); step(1'b1); step(1'b0);
    tests++; if (outs !== O_CAPDR) begin failed++; $display("FAIL tlr_to_cap_dr outs=%h exp=%h", outs, O_CAPDR); end
  endtask

  task automatic test_back_to_back;
    step(1'b1); step(1'b1);
    tests++; if (outs !== O_UPDR) begin failed++; $display("FAIL cap_exit_upd outs=%h exp=%h", outs, O_UPDR); end
    step(1'b0); step(1'b1); step(1'b0);
    tests++; if (outs !== O_CAPDR) begin failed++; $display("FAIL upd_rti_cap outs=%h exp=%h", outs, O_CAPDR); end
    step(1'b1); step(1'b1); step(1'b1); step(1'b1); step(1'b0);
    tests++; if (outs !== O_CAPIR) begin failed++; $display("FAIL upd_seldr_capir outs=%h exp=%h", outs, O_CAPIR); end
    step(1'b1); step(1'b1); step(1'b0); step(1'b1); step(1'b0);
    tests++; if (outs !== O_CAPDR) begin failed++; $display("FAIL updir_rti_cap outs=%h exp=%h", outs, O_CAPDR); end
  endtask

  task automatic test_async_reset;
    step(1'b0);
    tests++; if (outs !== O_SHDR) begin failed++; $display("FAIL pre_trst outs=%h exp=%h", outs, O_SHDR); end
    #2 TRST = 1'b0;
    #1;
    tests++; if (outs !== O_IDLE) begin failed++; $display("FAIL async_clear outs=%h exp=%h", outs, O_IDLE); end
    TMS = 1'b0;
    @(posedge TCK); #1;
    tests++; if (outs !== O_IDLE) begin failed++; $display("FAIL trst_hold outs=%h exp=%h", outs, O_IDLE); end
    #2 TRST = 1'b1;
    step(1'b1); step(1'b0); step(1'b1); step(1'b0);
    tests++; if (outs !== O_CAPDR) begin failed++; $display("FAIL post_trst_walk outs=%h exp=%h", outs, O_CAPDR); end
  endtask

  initial begin
    test_reset;
    test_dr_scan;
    test_ir_scan;
    test_pause;
    test_tlr_walk;
    test_back_to_back;
    test_async_reset;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
